// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states and line-level constants.
// The transmit path may import the same constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int   PARITY_GROUP = 8;
    localparam logic IDLE_LEVEL   = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line; both flops reset to the idle level
// so that reset never looks like a start bit.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic line_sync
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta      <= IDLE_LEVEL;
            line_sync <= IDLE_LEVEL;
        end else begin
            meta      <= line;
            line_sync <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_path.sv
// UART receive path: one line bit per clock, even parity per word or per byte,
// valid/ready delivery with overrun flag. UART_RX_SYNC_EN adds a 2-flop rx synchroniser.
module uart_rx_path
    import uart_pkg::*;
#(
    parameter int WIDTH_SIZE = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic                  PF,
    input  logic                  rx_ready,
    output logic [WIDTH_SIZE-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int IDX_W = $clog2(WIDTH_SIZE + 1);
    localparam int GRP_W = $clog2(PARITY_GROUP);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH_SIZE);

    rx_state_t             state;
    rx_state_t             state_next;
    logic                  rx_s;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_inc;
    logic [WIDTH_SIZE-1:0] shreg;
    logic                  par_run;
    logic                  perr_acc;
    logic                  pf_lat;

`ifdef UART_RX_SYNC_EN
    uart_rx_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .line      (rx),
        .line_sync (rx_s)
    );
`else
    assign rx_s = rx;
`endif

    assign idx_inc = idx + 1'b1;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (rx_s != IDLE_LEVEL) state_next = DATA;
            // A group parity bit follows every full byte in per-byte mode.
            DATA:   if (idx_inc == LAST_IDX || (pf_lat && idx_inc[GRP_W-1:0] == '0))
                        state_next = PARITY;
            PARITY: state_next = (idx == LAST_IDX) ? STOP : DATA;
            STOP:   state_next = (rx_s == IDLE_LEVEL) ? IDLE : BREAK;
            BREAK:  if (rx_s == IDLE_LEVEL) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Frame assembly; every field is re-initialised on start detection.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (rx_s != IDLE_LEVEL) begin
                    pf_lat   <= PF;
                    idx      <= '0;
                    shreg    <= '0;
                    par_run  <= 1'b0;
                    perr_acc <= 1'b0;
                end
            end
            DATA: begin
                shreg   <= {rx_s, shreg[WIDTH_SIZE-1:1]};
                idx     <= idx_inc;
                par_run <= par_run ^ rx_s;
            end
            PARITY: begin
                if (rx_s != par_run) perr_acc <= 1'b1;
                if (pf_lat) par_run <= 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (state == STOP) begin
            rx_data    <= shreg;
            rx_valid   <= 1'b1;
            parity_err <= perr_acc;
            frame_err  <= (rx_s != IDLE_LEVEL);
            overrun    <= rx_valid && !rx_ready;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

endmodule

// File: doc/uart_rx_path.md
Name: uart_rx_path

Overview:
- Serial receive stage directly downstream of the UART transmit path; consumes its one-bit-per-clock line (idle high, start 0, data LSB-first, even-parity bits, stop 1).
- Deserialises a WIDTH_SIZE-bit word, checks parity and stop bit, and presents the word on a valid/ready interface to the consumer.
- No oversampling: one line bit per clk, matching the transmitter's bit rate.

Parameters:
- WIDTH_SIZE, 8, data word width; must be a multiple of 8 (8, 16, 24, …).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising edge of clk).
- rx  input  1  serial line from the transmit path; idle high.
- PF  input  1  parity format, latched at start-bit detection: 0 = one parity bit after all data; 1 = one parity bit after every 8-bit group.
- rx_ready  input  1  consumer accepts the word when high with rx_valid.
- rx_data  output  WIDTH_SIZE  received word.
- rx_valid  output  1  word available; held until accepted.
- parity_err  output  1  any parity mismatch in the delivered word.
- frame_err  output  1  stop bit sampled as 0 for the delivered word.
- overrun  output  1  delivered word overwrote an unaccepted word.
- busy  output  1  frame in progress (state != IDLE).

Behaviour:
- Reset (reset=0 at clk edge): state IDLE; rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0; partial frame discarded.
- States: IDLE, DATA, PARITY, STOP, BREAK.
- IDLE: rx=0 sampled → start bit consumed; latch PF; clear bit index, shift register, running parity and error accumulators → DATA.
- DATA: shift rx into bit[index], index+1, parity ^= rx.
  - PF=1, group of 8 complete, index<WIDTH_SIZE → PARITY (then back to DATA).
  - index reaches WIDTH_SIZE → PARITY (final).
- PARITY: compare rx with running parity (even: XOR of covered bits); mismatch sets the error accumulator.
  - PF=1: running parity cleared after each group.
  - PF=0: single parity bit covers all WIDTH_SIZE bits.
  - After the final parity bit → STOP.
- STOP: sample rx.
  - rx=1 → IDLE.
  - rx=0 → frame_err for this word; → BREAK.
  - In both cases the word is delivered.
- BREAK: wait until rx=1 is sampled → IDLE. No start detection in BREAK.
- Frame length: PF=0 is WIDTH_SIZE+3 bits; PF=1 is WIDTH_SIZE+WIDTH_SIZE/8+2 bits.
- Delivery: rx_data, parity_err and frame_err are registered on the edge that samples the stop bit. rx_valid is high from the next cycle.
- Handshake:
  - rx_valid && rx_ready at an edge → rx_valid=0 next cycle unless a new word loads on that same edge.
  - rx_data and all flags stay stable while rx_valid=1 && rx_ready=0.
- Overrun:
  - A new word completes while rx_valid=1 and rx_ready=0 → the new word overwrites the old one, rx_valid stays 1, overrun=1.
  - If rx_ready=1 on that same edge → old word accepted, new word loads, overrun=0.
  - overrun clears when the word is accepted.
- Back-to-back frames: a start bit may be detected on the cycle immediately after STOP returns to IDLE.
- PF changes mid-frame are ignored.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined: rx passes through a 2-flop synchroniser (reset value 1) before the FSM; all sampling is delayed by 2 cycles.
- Undefined: rx is used directly; zero added latency.

Decomposition:
- Shared package uart_pkg:
  - rx state enum (IDLE, DATA, PARITY, STOP, BREAK), 3-bit logic;
  - PARITY_GROUP = 8;
  - IDLE_LEVEL = 1'b1.
  - The transmit path may reuse the constants.
- Sub-module uart_rx_sync: 2-flop synchroniser, instantiated only under UART_RX_SYNC_EN.

Test Plan:
- WIDTH=8, PF=0, rx_ready=1; line 0,1,0,1,0,0,1,0,1,0,1 (0xA5, parity 0, stop 1) → rx_data=0xA5, rx_valid one cycle after stop sample, parity_err=0, frame_err=0.
- Same frame with parity bit 1 (transmitter err inject) → rx_data=0xA5, parity_err=1.
- WIDTH=16, PF=1, 0x1234: bits of 0x34, parity 1, bits of 0x12, parity 0, stop 1 → rx_data=0x1234, no errors. Flip the first parity bit → parity_err=1.
- WIDTH=8, 0x3C frame with stop bit 0, then line held 0 for 5 cycles → frame_err=1, no new start while low; after rx=1, a 0x81 frame is received correctly.
- rx_ready=0, two back-to-back frames 0x11 then 0x22 → rx_data=0x22, overrun=1. Raising rx_ready for one cycle → rx_valid=0, overrun=0.
- Reset (reset=0) asserted mid-data of a 0x55 frame, then a 0x0F frame → no delivery of 0x55; rx_data=0x0F, all flags 0.
